// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the instruction decoder and pc_sequencer.
// CycleCount exists only when PC_SEQ_CYCLE_COUNT_EN is defined.
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 10
);
  logic            Start;
  logic            Branch;
  logic            Jump;
  logic            Zero;
  logic            MemOp;
  logic            MemReady;
  logic            Halt;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] PC;
  logic            InstEn;
  logic            CommitEn;
  logic            MemReq;
  logic            Done;
`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [15:0]     CycleCount;
`endif

  modport master (
    output Start, Branch, Jump, Zero, MemOp, MemReady, Halt, Target,
`ifdef PC_SEQ_CYCLE_COUNT_EN
    input  CycleCount,
`endif
    input  PC, InstEn, CommitEn, MemReq, Done
  );

  modport slave (
    input  Start, Branch, Jump, Zero, MemOp, MemReady, Halt, Target,
`ifdef PC_SEQ_CYCLE_COUNT_EN
    output CycleCount,
`endif
    output PC, InstEn, CommitEn, MemReq, Done
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer: IDLE -> FETCH -> EXEC [-> MEM] -> FETCH ... -> DONE.
// Optional feature macro: PC_SEQ_CYCLE_COUNT_EN adds a saturating 16-bit CycleCount output.
module pc_sequencer #(
  parameter int unsigned PC_W = 10
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            inst_en_q, inst_en_d;
  logic            mem_req_q, mem_req_d;
  logic            done_q, done_d;
  logic            commit_en;
  logic            start_acc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    commit_en = 1'b0;
    start_acc = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          start_acc = 1'b1;
          pc_d      = '0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (bus.Halt) begin
          state_d = DONE;
        end else if (bus.MemOp) begin
          state_d = MEM;
        end else begin
          commit_en = 1'b1;
          state_d   = FETCH;
          if (bus.Jump || (bus.Branch && bus.Zero)) begin
            pc_d = bus.Target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      MEM: begin
        if (bus.MemReady) begin
          commit_en = 1'b1;
          pc_d      = pc_q + PC_W'(1);
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they carry no input-to-output path.
    inst_en_d = (state_d == FETCH);
    mem_req_d = (state_d == MEM);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_en_q <= 1'b0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_en_q <= inst_en_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.InstEn   = inst_en_q;
  assign bus.CommitEn = commit_en;
  assign bus.MemReq   = mem_req_q;
  assign bus.Done     = done_q;

`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (start_acc) begin
      cycle_cnt_d = '0;
    end else if ((state_q == FETCH || state_q == EXEC || state_q == MEM) &&
                 (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.CycleCount = cycle_cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; CycleCount checks build only with PC_SEQ_CYCLE_COUNT_EN.
module tb_pc_sequencer;
  localparam int unsigned PC_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W)) bus();

  pc_sequencer #(.PC_W(PC_W)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            start;
    logic            branch;
    logic            jump;
    logic            zero;
    logic            mem_ready;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.Start    = 1'b0;
    bus.Branch   = 1'b0;
    bus.Jump     = 1'b0;
    bus.Zero     = 1'b0;
    bus.MemOp    = 1'b0;
    bus.MemReady = 1'b0;
    bus.Halt     = 1'b0;
    bus.Target   = '0;
  endtask

  // One plain (non-memory) instruction: FETCH -> EXEC -> FETCH.
  task automatic run_plain();
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h155, 10'h001};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0AA, 10'h002};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h033, 10'h003};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h02A, 10'h02A};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h010, 10'h02B};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h100, 10'h100};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h055, 10'h000};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h077, 10'h001};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h020, 10'h020};

    clr_in();
    rst_n = 1'b0;
    #3;
    check("rst_pc",     32'(bus.PC), 32'h0);
    check("rst_insten", 32'(bus.InstEn), 32'h0);
    check("rst_commit", 32'(bus.CommitEn), 32'h0);
    check("rst_memreq", 32'(bus.MemReq), 32'h0);
    check("rst_done",   32'(bus.Done), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_insten", 32'(bus.InstEn), 32'h0);
    check("idle_done",   32'(bus.Done), 32'h0);

    // Start, then Halt at the first EXEC.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("start_insten", 32'(bus.InstEn), 32'h1);
    check("start_pc",     32'(bus.PC), 32'h0);
    tick();
    bus.Halt = 1'b1;
    bus.MemOp = 1'b1;
    bus.Jump = 1'b1;
    bus.Target = 10'h123;
    #1;
    check("halt_commit", 32'(bus.CommitEn), 32'h0);
    check("exec_insten", 32'(bus.InstEn), 32'h0);
    check("halt_done_early", 32'(bus.Done), 32'h0);
    tick();
    clr_in();
    check("halt_done",   32'(bus.Done), 32'h1);
    check("halt_pc",     32'(bus.PC), 32'h0);
    check("halt_memreq", 32'(bus.MemReq), 32'h0);
    check("halt_insten", 32'(bus.InstEn), 32'h0);
    tick();
    check("done_hold", 32'(bus.Done), 32'h1);

    // Restart from DONE, then run the vector table.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("restart_done", 32'(bus.Done), 32'h0);
    check("restart_pc",   32'(bus.PC), 32'h0);

    for (int i = 0; i < 10; i++) begin
      check($sformatf("v%0d_fetch_insten", i), 32'(bus.InstEn), 32'h1);
      tick();
      check($sformatf("v%0d_exec_insten", i), 32'(bus.InstEn), 32'h0);
      bus.Start    = vecs[i].start;
      bus.Branch   = vecs[i].branch;
      bus.Jump     = vecs[i].jump;
      bus.Zero     = vecs[i].zero;
      bus.MemReady = vecs[i].mem_ready;
      bus.Target   = vecs[i].target;
      #1;
      check($sformatf("v%0d_commit", i), 32'(bus.CommitEn), 32'h1);
      tick();
      clr_in();
      check($sformatf("v%0d_pc", i), 32'(bus.PC), 32'(vecs[i].exp_pc));
      check($sformatf("v%0d_memreq", i), 32'(bus.MemReq), 32'h0);
    end

    // Memory instruction with MemReady in the 4th MEM cycle; Start in MEM ignored.
    tick();
    bus.MemOp = 1'b1;
    #1;
    check("memop_commit", 32'(bus.CommitEn), 32'h0);
    tick();
    bus.MemOp = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.Start    = (c == 2);
      bus.MemReady = (c == 4);
      #1;
      check($sformatf("mem_c%0d_memreq", c), 32'(bus.MemReq), 32'h1);
      check($sformatf("mem_c%0d_commit", c), 32'(bus.CommitEn), (c == 4) ? 32'h1 : 32'h0);
      check($sformatf("mem_c%0d_pc", c), 32'(bus.PC), 32'h020);
      tick();
    end
    clr_in();
    check("mem_after_memreq", 32'(bus.MemReq), 32'h0);
    check("mem_after_pc",     32'(bus.PC), 32'h021);
    check("mem_after_insten", 32'(bus.InstEn), 32'h1);

    // Asynchronous reset while waiting in MEM.
    tick();
    bus.MemOp = 1'b1;
    tick();
    bus.MemOp = 1'b0;
    check("rmem_memreq", 32'(bus.MemReq), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmem_memreq_drop", 32'(bus.MemReq), 32'h0);
    check("rmem_pc",          32'(bus.PC), 32'h0);
    #2;
    rst_n = 1'b1;
    bus.MemReady = 1'b1;
    tick();
    bus.MemReady = 1'b0;
    check("rmem_idle_insten", 32'(bus.InstEn), 32'h0);
    check("rmem_idle_memreq", 32'(bus.MemReq), 32'h0);
    check("rmem_idle_pc",     32'(bus.PC), 32'h0);

    // plain, plain, mem (ready at once), plain, halt: 11 active cycles.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("cc_fetch_insten", 32'(bus.InstEn), 32'h1);
`ifdef PC_SEQ_CYCLE_COUNT_EN
    check("cc_start", 32'(bus.CycleCount), 32'h0);
`endif
    run_plain();
    run_plain();
    tick();
    bus.MemOp = 1'b1;
    tick();
    bus.MemOp = 1'b0;
    bus.MemReady = 1'b1;
    tick();
    bus.MemReady = 1'b0;
    run_plain();
    tick();
    bus.Halt = 1'b1;
    tick();
    bus.Halt = 1'b0;
    check("cc_done", 32'(bus.Done), 32'h1);
    check("cc_pc",   32'(bus.PC), 32'h4);
    tick();
`ifdef PC_SEQ_CYCLE_COUNT_EN
    check("cc_total", 32'(bus.CycleCount), 32'd11);
`endif
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("cc_restart_insten", 32'(bus.InstEn), 32'h1);
`ifdef PC_SEQ_CYCLE_COUNT_EN
    check("cc_restart_clear", 32'(bus.CycleCount), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
